// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the hazard controller and the
// pipeline registers that consume its choice codes.
//   choice_t      2-bit register control code (FLUSH / LOAD / HOLD)
//   choice_vec_t  one choice per controlled register, PC first
//   md_state_e    mult/div tracker FSM states
package hazard_ctrl_pkg;

    typedef logic [1:0] choice_t;

    localparam choice_t CH_FLUSH = 2'b00;
    localparam choice_t CH_LOAD  = 2'b01;
    localparam choice_t CH_HOLD  = 2'b10;

    typedef struct packed {
        choice_t pc;
        choice_t ifid;
        choice_t idex;
        choice_t exmem;
        choice_t memwb;
    } choice_vec_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic choice_vec_t choice_all(input choice_t c);
        choice_vec_t v;
        v = '{pc: c, ifid: c, idex: c, exmem: c, memwb: c};
        return v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline status into the hazard controller and the choice
// codes back out to the pipeline registers.
//   master: pipeline side (drives ID/EX/MEM status, receives choices)
//   slave : hazard controller side
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_md_use;
    logic       id_jump;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       ex_md_start;
    logic       ex_md_is_div;
    logic       mem_stall;

    choice_t    pc_choice;
    choice_t    ifid_choice;
    choice_t    idex_choice;
    choice_t    exmem_choice;
    choice_t    memwb_choice;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_md_use, id_jump,
               ex_mem_read, ex_rd, ex_branch_taken, ex_md_start,
               ex_md_is_div, mem_stall,
        input  pc_choice, ifid_choice, idex_choice, exmem_choice, memwb_choice
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_use, id_jump,
               ex_mem_read, ex_rd, ex_branch_taken, ex_md_start,
               ex_md_is_div, mem_stall,
        output pc_choice, ifid_choice, idex_choice, exmem_choice, memwb_choice
    );

endinterface

// File: rtl/hazard_ctrl_md_tracker.sv
// md_tracker: shadows the multi-cycle mult/div unit.
//   clk, reset  clock, async active-low reset
//   start       qualified start (already gated by stall/branch in the parent)
//   is_div      1 = divide, 0 = multiply
//   md_busy     operation in flight
//   md_done     high during the final busy cycle
module md_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy,
    output logic md_done
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter runs regardless of pipeline stalls: the unit itself never
    // freezes. A start while busy is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = is_div ? DIV_LD : MULT_LD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) state_d = MD_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);
    assign md_done = (state_q == MD_BUSY) && (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller driving the choice codes of the
// PC and the four pipeline registers.
//   clk, reset  clock, async active-low reset (choices forced FLUSH while low)
//   hz          pipeline status in / choice codes out (slave side)
//   md_busy     mult/div unit busy
//   md_done     mult/div completion pulse
//   stall_cnt   saturating count of cycles with the PC held
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16,
    parameter int CNT_W       = 5,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    hazard_ctrl_if.slave      hz,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cnt
);

    logic        load_use, md_haz, md_start;
    choice_vec_t ch;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));
    assign md_haz   = md_busy && hz.id_md_use;

    // A start that is frozen or squashed this cycle never reaches the unit.
    assign md_start = hz.ex_md_start && !hz.mem_stall && !hz.ex_branch_taken;

    md_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .is_div  (hz.ex_md_is_div),
        .md_busy (md_busy),
        .md_done (md_done)
    );

    // A taken branch beats data stalls since the stalled ID instruction is
    // squashed anyway. A jump waits behind any stall and redirects afterwards.
    always_comb begin
        ch = choice_all(CH_LOAD);
        if (!reset) begin
            ch = choice_all(CH_FLUSH);
        end else if (hz.mem_stall) begin
            ch = choice_all(CH_HOLD);
        end else if (hz.ex_branch_taken) begin
            ch.ifid = CH_FLUSH;
            ch.idex = CH_FLUSH;
        end else if (load_use || md_haz) begin
            ch.pc   = CH_HOLD;
            ch.ifid = CH_HOLD;
            ch.idex = CH_FLUSH;
        end else if (hz.id_jump) begin
            ch.ifid = CH_FLUSH;
        end
    end

    assign hz.pc_choice    = ch.pc;
    assign hz.ifid_choice  = ch.ifid;
    assign hz.idex_choice  = ch.idex;
    assign hz.exmem_choice = ch.exmem;
    assign hz.memwb_choice = ch.memwb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (ch.pc == CH_HOLD && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [9:0] ALL_LD = 10'b01_01_01_01_01;
    localparam logic [9:0] LU     = 10'b10_10_00_01_01;
    localparam logic [9:0] BR     = 10'b01_00_00_01_01;
    localparam logic [9:0] JMP    = 10'b01_00_01_01_01;
    localparam logic [9:0] MS     = 10'b10_10_10_10_10;
    localparam logic [9:0] RST    = 10'b00_00_00_00_00;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_busy, md_done;
    logic [31:0] stall_cnt;
    logic [9:0]  ch;
    int          errs = 0;
    int          checks = 0;
    int          exp_sc = 0;

    hazard_ctrl_if hif();

    hazard_ctrl #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (16),
        .CNT_W       (5),
        .PERF_W      (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hz        (hif.slave),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    assign ch = {hif.pc_choice, hif.ifid_choice, hif.idex_choice,
                 hif.exmem_choice, hif.memwb_choice};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        hif.id_rs = 5'd0; hif.id_rt = 5'd0;
        hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
        hif.id_md_use = 1'b0; hif.id_jump = 1'b0;
        hif.ex_mem_read = 1'b0; hif.ex_rd = 5'd0;
        hif.ex_branch_taken = 1'b0; hif.ex_md_start = 1'b0;
        hif.ex_md_is_div = 1'b0; hif.mem_stall = 1'b0;
    endtask

    // Check this cycle's combinational outputs, clock once, check stall_cnt.
    task automatic cyc(input string tag, input logic [9:0] exp_ch,
                       input logic exp_busy, input logic exp_done);
        #1;
        check({tag, ".ch"}, 32'(ch), 32'(exp_ch));
        check({tag, ".busy"}, 32'(md_busy), 32'(exp_busy));
        check({tag, ".done"}, 32'(md_done), 32'(exp_done));
        if (exp_ch[9:8] == CH_HOLD) exp_sc++;
        @(posedge clk); #1;
        check({tag, ".scnt"}, stall_cnt, 32'(exp_sc));
    endtask

    task automatic load_use_rs(input logic [4:0] rd);
        hif.ex_mem_read = 1'b1; hif.ex_rd = rd;
        hif.id_rs = 5'd8; hif.id_use_rs = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        check("rst.ch", 32'(ch), 32'(RST));
        check("rst.busy", 32'(md_busy), 32'd0);
        check("rst.scnt", stall_cnt, 32'd0);
        reset = 1'b1;

        // 1: idle pipe
        for (int i = 0; i < 3; i++) cyc("idle", ALL_LD, 1'b0, 1'b0);

        // 2: load-use on rs, then rd=0, then rt, then rt match but unused
        load_use_rs(5'd8);   cyc("lu_rs", LU, 1'b0, 1'b0); clr();
        load_use_rs(5'd0);   hif.id_rs = 5'd0;
        cyc("lu_r0", ALL_LD, 1'b0, 1'b0); clr();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd9; hif.id_rt = 5'd9; hif.id_use_rt = 1'b1;
        cyc("lu_rt", LU, 1'b0, 1'b0);
        hif.id_use_rt = 1'b0;
        cyc("lu_nouse", ALL_LD, 1'b0, 1'b0); clr();
        load_use_rs(5'd8);   hif.ex_mem_read = 1'b0;
        cyc("lu_noload", ALL_LD, 1'b0, 1'b0); clr();

        // 3: branch beats load-use; plain jump
        load_use_rs(5'd8);   hif.ex_branch_taken = 1'b1;
        cyc("br_lu", BR, 1'b0, 1'b0); clr();
        hif.id_jump = 1'b1;
        cyc("jump", JMP, 1'b0, 1'b0); clr();

        // 4: divide then multiply with a dependent mfhi/mflo waiting in ID
        hif.ex_md_start = 1'b1; hif.ex_md_is_div = 1'b1;
        cyc("div_start", ALL_LD, 1'b0, 1'b0); clr();
        hif.id_md_use = 1'b1;
        for (int i = 1; i <= 16; i++) cyc("div_busy", LU, 1'b1, i == 16);
        cyc("div_after", ALL_LD, 1'b0, 1'b0); clr();
        hif.ex_md_start = 1'b1;
        cyc("mul_start", ALL_LD, 1'b0, 1'b0); clr();
        hif.id_md_use = 1'b1;
        for (int i = 1; i <= 4; i++) cyc("mul_busy", LU, 1'b1, i == 4);
        cyc("mul_after", ALL_LD, 1'b0, 1'b0); clr();

        // 5: mem_stall over jump + load-use, then load-use, then jump
        hif.id_jump = 1'b1; load_use_rs(5'd8); hif.mem_stall = 1'b1;
        cyc("ms_all", MS, 1'b0, 1'b0);
        hif.mem_stall = 1'b0;
        cyc("ms_lu", LU, 1'b0, 1'b0);
        hif.ex_mem_read = 1'b0;
        cyc("ms_jump", JMP, 1'b0, 1'b0); clr();

        // Counter keeps running under mem_stall; gated starts are dropped
        hif.ex_md_start = 1'b1;
        cyc("mulms_start", ALL_LD, 1'b0, 1'b0); clr();
        hif.mem_stall = 1'b1;
        for (int i = 1; i <= 4; i++) cyc("mulms_busy", MS, 1'b1, i == 4);
        clr();
        cyc("mulms_after", ALL_LD, 1'b0, 1'b0);
        hif.ex_md_start = 1'b1; hif.mem_stall = 1'b1;
        cyc("start_ms", MS, 1'b0, 1'b0); clr();
        cyc("start_ms_drop", ALL_LD, 1'b0, 1'b0);
        hif.ex_md_start = 1'b1; hif.ex_branch_taken = 1'b1;
        cyc("start_br", BR, 1'b0, 1'b0); clr();
        cyc("start_br_drop", ALL_LD, 1'b0, 1'b0);

        // Back-to-back: start in done cycle ignored, next cycle accepted
        hif.ex_md_start = 1'b1;
        cyc("b2b_start", ALL_LD, 1'b0, 1'b0); clr();
        for (int i = 1; i <= 3; i++) cyc("b2b_busy", ALL_LD, 1'b1, 1'b0);
        hif.ex_md_start = 1'b1;
        cyc("b2b_done", ALL_LD, 1'b1, 1'b1);
        cyc("b2b_restart", ALL_LD, 1'b0, 1'b0); clr();
        for (int i = 1; i <= 4; i++) cyc("b2b_busy2", ALL_LD, 1'b1, i == 4);
        cyc("b2b_after", ALL_LD, 1'b0, 1'b0);

        // 6: reset with divide counter at 7
        hif.ex_md_start = 1'b1; hif.ex_md_is_div = 1'b1;
        cyc("rdiv_start", ALL_LD, 1'b0, 1'b0); clr();
        hif.id_md_use = 1'b1;
        for (int i = 1; i <= 8; i++) cyc("rdiv_busy", LU, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("rmid.ch", 32'(ch), 32'(RST));
        check("rmid.busy", 32'(md_busy), 32'd0);
        check("rmid.done", 32'(md_done), 32'd0);
        check("rmid.scnt", stall_cnt, 32'd0);
        exp_sc = 0;
        @(posedge clk); #1;
        check("rmid.ch2", 32'(ch), 32'(RST));
        reset = 1'b1;
        for (int i = 0; i < 17; i++) cyc("rpost", ALL_LD, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
